// File: rtl/psi_index_serializer.sv
// psi_index_serializer
//   Streams the indices of the set bits in a W-bit PSI intersection bitmap,
//   lowest index first, one index per valid/ready beat. The captured bitmap
//   is scanned CHUNK bits per cycle, so long runs of zero bits are skipped
//   quickly. An all-zero bitmap produces a single beat with index 0 and
//   out_empty=1.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-low
//   in_valid   bitmap offered by upstream
//   in_ready   block idle and will capture the bitmap
//   in_bitmap  W-bit intersection bitmap
//   out_valid  out_idx / out_last / out_empty are valid
//   out_ready  downstream accepts the current beat
//   out_idx    index of a set bit
//   out_last   final beat for this bitmap
//   out_empty  bitmap was all-zero (single index-0 beat)
//   out_count  beats accepted so far for the current bitmap
module psi_index_serializer #(
    parameter int W     = 10,
    parameter int CHUNK = 4,
    parameter int IW    = (W > 1) ? $clog2(W) : 1,
    parameter int CW    = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_bitmap,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_idx,
    output logic          out_last,
    output logic          out_empty,
    output logic [CW-1:0] out_count
);

    localparam int NCHUNK = (W + CHUNK - 1) / CHUNK;
    localparam int PW     = NCHUNK * CHUNK;
    localparam int PTRW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int CPW    = (CHUNK > 1) ? $clog2(CHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_EMIT
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [W-1:0]    r_mask,  w_mask_nxt;
    logic [PTRW-1:0] r_ptr,   w_ptr_nxt;
    logic [IW-1:0]   r_idx,   w_idx_nxt;
    logic            r_last,  w_last_nxt;
    logic            r_empty, w_empty_nxt;
    logic [CW-1:0]   r_count, w_count_nxt;

    // Mask zero-extended to a whole number of chunks so the final partial
    // chunk reads its out-of-range bits as 0.
    logic [PW-1:0]    w_mask_pad;
    logic [31:0]      w_base;
    logic [CHUNK-1:0] w_chunk;
    logic [CHUNK-1:0] w_chunk_low;
    logic [CPW-1:0]   w_pos;
    logic [W-1:0]     w_mask_clr;

    assign w_mask_pad  = PW'(r_mask);
    assign w_base      = 32'(r_ptr) * 32'(CHUNK);
    assign w_chunk     = CHUNK'(w_mask_pad >> w_base);
    // Two's-complement trick isolates the lowest set bit of the chunk.
    assign w_chunk_low = w_chunk & (~w_chunk + CHUNK'(1));
    assign w_mask_clr  = W'(w_mask_pad & ~(PW'(w_chunk_low) << w_base));

    // Priority encoder: walk from the top so the lowest set bit wins.
    always_comb begin
        w_pos = '0;
        for (int unsigned i = CHUNK; i > 0; i--) begin
            if (w_chunk[i-1]) begin
                w_pos = CPW'(i - 1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_ptr_nxt   = r_ptr;
        w_idx_nxt   = r_idx;
        w_last_nxt  = r_last;
        w_empty_nxt = r_empty;
        w_count_nxt = r_count;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_mask_nxt  = in_bitmap;
                    w_ptr_nxt   = '0;
                    w_count_nxt = '0;
                    if (in_bitmap != '0) begin
                        w_state_nxt = S_SCAN;
                    end else begin
                        w_state_nxt = S_EMIT;
                        w_idx_nxt   = '0;
                        w_empty_nxt = 1'b1;
                        w_last_nxt  = 1'b1;
                    end
                end
            end
            S_SCAN: begin
                if (w_chunk != '0) begin
                    w_idx_nxt   = IW'(w_base + 32'(w_pos));
                    w_mask_nxt  = w_mask_clr;
                    w_last_nxt  = (w_mask_clr == '0);
                    w_state_nxt = S_EMIT;
                end else begin
                    // Mask is non-zero here, so the pointer cannot run past
                    // the final chunk.
                    w_ptr_nxt = r_ptr + PTRW'(1);
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    w_count_nxt = r_count + CW'(1);
                    if (r_last) begin
                        w_state_nxt = S_IDLE;
                        w_empty_nxt = 1'b0;
                    end else begin
                        // Pointer kept: the same chunk may hold more bits.
                        w_state_nxt = S_SCAN;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_mask  <= '0;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_last  <= 1'b0;
            r_empty <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_nxt;
            r_ptr   <= w_ptr_nxt;
            r_idx   <= w_idx_nxt;
            r_last  <= w_last_nxt;
            r_empty <= w_empty_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_EMIT);
    assign out_idx   = r_idx;
    assign out_last  = r_last;
    assign out_empty = r_empty;
    assign out_count = r_count;

endmodule

// File: tb/tb_psi_index_serializer.sv
module tb_psi_index_serializer;

    localparam int SW  = 10;
    localparam int SC  = 4;
    localparam int BW  = 10000;
    localparam int BC  = 64;
    localparam int SIW = $clog2(SW);
    localparam int SCW = $clog2(SW + 1);
    localparam int BIW = $clog2(BW);
    localparam int BCW = $clog2(BW + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          sel;
    logic          drv_valid;
    logic [BW-1:0] drv_bitmap;
    logic          drv_ready;

    logic           s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_last, s_out_empty;
    logic [SW-1:0]  s_in_bitmap;
    logic [SIW-1:0] s_out_idx;
    logic [SCW-1:0] s_out_count;

    logic           b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_out_empty;
    logic [BW-1:0]  b_in_bitmap;
    logic [BIW-1:0] b_out_idx;
    logic [BCW-1:0] b_out_count;

    assign s_in_valid  = drv_valid & ~sel;
    assign s_out_ready = drv_ready & ~sel;
    assign s_in_bitmap = drv_bitmap[SW-1:0];
    assign b_in_valid  = drv_valid & sel;
    assign b_out_ready = drv_ready & sel;
    assign b_in_bitmap = drv_bitmap;

    psi_index_serializer #(.W(SW), .CHUNK(SC)) u_small (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_bitmap(s_in_bitmap),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_idx(s_out_idx),
        .out_last(s_out_last), .out_empty(s_out_empty), .out_count(s_out_count)
    );

    psi_index_serializer #(.W(BW), .CHUNK(BC)) u_big (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_bitmap(b_in_bitmap),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_idx(b_out_idx),
        .out_last(b_out_last), .out_empty(b_out_empty), .out_count(b_out_count)
    );

    logic [31:0] m_in_ready, m_out_valid, m_last, m_empty, m_idx, m_count;
    assign m_in_ready  = 32'(sel ? b_in_ready  : s_in_ready);
    assign m_out_valid = 32'(sel ? b_out_valid : s_out_valid);
    assign m_last      = 32'(sel ? b_out_last  : s_out_last);
    assign m_empty     = 32'(sel ? b_out_empty : s_out_empty);
    assign m_idx       = sel ? 32'(b_out_idx)   : 32'(s_out_idx);
    assign m_count     = sel ? 32'(b_out_count) : 32'(s_out_count);

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: expected beats are simply the set-bit positions in ascending
    // order (or a single index-0 beat for an empty bitmap); first-beat latency is
    // one cycle per chunk up to and including the chunk of the lowest index.
    task automatic run_case(input logic [BW-1:0] bm, input int rdy_pct,
                            input bit inject, input string tag);
        int          w;
        int          ch;
        int          q[$];
        int          total;
        int          lat;
        int          exp_lat;
        int          guard;
        int          it;
        int          acc;
        bit          exp_empty;
        bit          held;
        logic [31:0] h_idx, h_last, h_empty;
        w  = sel ? BW : SW;
        ch = sel ? BC : SC;
        for (int i = 0; i < w; i++) begin
            if (bm[i]) q.push_back(i);
        end
        exp_empty = (q.size() == 0);
        if (exp_empty) q.push_back(0);
        total   = q.size();
        exp_lat = exp_empty ? 0 : (q[0] / ch + 1);

        guard = 0;
        while (m_in_ready !== 32'd1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "/in_ready_idle"}, m_in_ready, 32'd1);

        drv_bitmap = bm;
        drv_valid  = 1'b1;
        drv_ready  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        drv_valid = 1'b0;

        lat = 0;
        while (m_out_valid !== 32'd1 && lat < BW) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));

        held = 1'b0;
        acc  = 0;
        it   = 0;
        h_idx = '0; h_last = '0; h_empty = '0;
        while (q.size() > 0 && it < 3000) begin
            if (inject && it == 3) begin
                chk({tag, "/in_ready_busy"}, m_in_ready, 32'd0);
                drv_bitmap = ~bm;
                drv_valid  = 1'b1;
            end else begin
                drv_valid = 1'b0;
            end
            if (m_out_valid === 32'd1) begin
                if (held) begin
                    chk({tag, "/stall_idx"},   m_idx,   h_idx);
                    chk({tag, "/stall_last"},  m_last,  h_last);
                    chk({tag, "/stall_empty"}, m_empty, h_empty);
                end
                drv_ready = ($urandom_range(99) < rdy_pct);
                if (drv_ready) begin
                    chk({tag, "/idx"},   m_idx,   32'(q[0]));
                    chk({tag, "/last"},  m_last,  32'(q.size() == 1));
                    chk({tag, "/empty"}, m_empty, 32'(exp_empty));
                    chk({tag, "/count"}, m_count, 32'(acc));
                    void'(q.pop_front());
                    acc++;
                    held = 1'b0;
                end else begin
                    held    = 1'b1;
                    h_idx   = m_idx;
                    h_last  = m_last;
                    h_empty = m_empty;
                end
            end else begin
                drv_ready = 1'b0;
                if (held) chk({tag, "/valid_dropped"}, m_out_valid, 32'd1);
                held = 1'b0;
            end
            @(negedge clk);
            it++;
        end
        drv_valid = 1'b0;
        drv_ready = 1'b0;
        chk({tag, "/beats_left"},  32'(q.size()), 32'd0);
        chk({tag, "/done_valid"},  m_out_valid,   32'd0);
        chk({tag, "/done_ready"},  m_in_ready,    32'd1);
        chk({tag, "/done_count"},  m_count,       32'(total));
        chk({tag, "/done_empty"},  m_empty,       32'd0);
    endtask

    initial begin
        logic [SW-1:0] r10;
        logic [BW-1:0] bb;
        int            acc;
        int            guard;

        rst        = 1'b0;
        sel        = 1'b0;
        drv_valid  = 1'b0;
        drv_ready  = 1'b0;
        drv_bitmap = '0;
        repeat (3) @(negedge clk);
        chk("rst/out_valid", m_out_valid, 32'd0);
        chk("rst/out_last",  m_last,      32'd0);
        chk("rst/out_empty", m_empty,     32'd0);
        chk("rst/out_idx",   m_idx,       32'd0);
        chk("rst/out_count", m_count,     32'd0);
        chk("rst/in_ready",  m_in_ready,  32'd1);
        rst = 1'b1;
        @(negedge clk);

        run_case(BW'(10'b10_0010_0101), 100, 1'b0, "t1");
        run_case(BW'(10'b0),            100, 1'b0, "t2");
        run_case(BW'(10'h3FF),           50, 1'b0, "t3");
        run_case(BW'(10'b10_0000_0000), 100, 1'b0, "t4");

        // Reset in the middle of a stream, after two accepted beats.
        drv_bitmap = BW'(10'b10_0010_0101);
        drv_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drv_valid = 1'b0;
        drv_ready = 1'b1;
        acc   = 0;
        guard = 0;
        while (acc < 2 && guard < 50) begin
            if (m_out_valid === 32'd1) acc++;
            @(negedge clk);
            guard++;
        end
        drv_ready = 1'b0;
        chk("t5/accepted", 32'(acc), 32'd2);
        chk("t5/count_pre", m_count, 32'd2);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        chk("t5/out_valid", m_out_valid, 32'd0);
        chk("t5/in_ready",  m_in_ready,  32'd1);
        chk("t5/out_count", m_count,     32'd0);
        chk("t5/out_idx",   m_idx,       32'd0);
        chk("t5/out_last",  m_last,      32'd0);
        run_case(BW'(10'b1), 100, 1'b0, "t5b");

        run_case(BW'(10'b10_0010_0101), 70, 1'b1, "t6inj");

        for (int n = 0; n < 30; n++) begin
            r10 = SW'($urandom);
            if ($urandom_range(1) == 1) r10 = r10 & SW'($urandom);
            run_case(BW'(r10), int'($urandom_range(30, 100)), 1'b0, "rnd");
        end

        sel = 1'b1;
        @(negedge clk);
        bb = '0;
        bb[0]    = 1'b1;
        bb[BW-1] = 1'b1;
        run_case(bb, 100, 1'b0, "big");
        for (int n = 0; n < 4; n++) begin
            bb = '0;
            for (int k = 0; k < int'($urandom_range(1, 6)); k++) begin
                bb[$urandom_range(BW - 1)] = 1'b1;
            end
            run_case(bb, int'($urandom_range(40, 100)), 1'b0, "bigrnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
